// File: rtl/div_16x8_seq.sv
// Sequential restoring divider: N_BITS-bit dividend / D_BITS-bit divisor, one quotient bit per
// cycle, with valid/ready handshakes on the operand and result sides.
module div_16x8_seq #(
  parameter int unsigned N_BITS = 16,
  parameter int unsigned D_BITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] A,
  input  logic [D_BITS-1:0] B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] Q,
  output logic [D_BITS-1:0] Rem,
  output logic              dbz
);

  localparam int unsigned IW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [IW-1:0] LastIter = IW'(N_BITS - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [N_BITS-1:0] a_q, a_d;
  logic [D_BITS-1:0] b_q, b_d;
  logic [D_BITS:0]   r_q, r_d;
  logic [N_BITS-1:0] quo_q, quo_d;
  logic [IW-1:0]     iter_q, iter_d;
  logic [N_BITS-1:0] q_q, q_d;
  logic [D_BITS-1:0] rem_q, rem_d;
  logic              dbz_q, dbz_d;

  // One restoring step. r_q < B between steps, so its top bit is always free for the shift.
  logic [D_BITS:0]   r_shift;
  logic [D_BITS:0]   r_step;
  logic              q_bit;
  logic [N_BITS-1:0] quo_step;

  always_comb begin
    r_shift  = {r_q[D_BITS-1:0], a_q[N_BITS-1]};
    q_bit    = (r_shift >= {1'b0, b_q});
    r_step   = q_bit ? (r_shift - {1'b0, b_q}) : r_shift;
    quo_step = {quo_q[N_BITS-2:0], q_bit};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    quo_d   = quo_q;
    iter_d  = iter_q;
    q_d     = q_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d = A;
          b_d = B;
          if (B != '0) begin
            r_d     = '0;
            quo_d   = '0;
            iter_d  = '0;
            state_d = StBusy;
          end else begin
            // Divide by zero: all-ones quotient, low dividend bits as remainder.
            q_d     = '1;
            rem_d   = A[D_BITS-1:0];
            dbz_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StBusy: begin
        a_d    = {a_q[N_BITS-2:0], 1'b0};
        r_d    = r_step;
        quo_d  = quo_step;
        iter_d = iter_q + IW'(1);
        if (iter_q == LastIter) begin
          iter_d  = '0;
          q_d     = quo_step;
          rem_d   = r_step[D_BITS-1:0];
          dbz_d   = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      quo_q   <= '0;
      iter_q  <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      quo_q   <= quo_d;
      iter_q  <= iter_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign Q         = q_q;
  assign Rem       = rem_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_div_16x8_seq.sv
// Self-checking bench for div_16x8_seq: directed vector table, back-pressure and mid-op reset
// sequences, and a randomised run against an A/B, A%B reference.
module tb_div_16x8_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [7:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Q;
  logic [7:0]  Rem;
  logic        dbz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_16x8_seq #(.N_BITS(16), .D_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .Rem       (Rem),
    .dbz       (dbz)
  );

  // lat counts clock edges after the accepting edge until out_valid is seen high;
  // 0 means out_valid is already high in the cycle right after acceptance.
  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge: presents operands until accepted, returns at the negedge after acceptance.
  task automatic start_op(input logic [15:0] a, input logic [7:0] b);
    int n = 0;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL start_timeout actual=in_ready_low required=in_ready_high");
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    A        = 16'hDEAD;
    B        = 8'hBE;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    out_ready = 1'b1;
    start_op(v.a, v.b);
    wait_done(lat);
    check({tag, "_latency"}, lat, v.lat);
    check({tag, "_Q"}, {16'd0, Q}, {16'd0, v.q});
    check({tag, "_Rem"}, {24'd0, Rem}, {24'd0, v.r});
    check({tag, "_dbz"}, {31'd0, dbz}, {31'd0, v.dz});
    @(negedge clk);
    check({tag, "_valid_one_cycle"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int handshakes;
    vecs[0] = '{16'd50000, 8'd200, 16'd250,    8'd0,   1'b0, 16};
    vecs[1] = '{16'd1000,  8'd7,   16'd142,    8'd6,   1'b0, 16};
    vecs[2] = '{16'hFFFF,  8'hFF,  16'h0101,   8'd0,   1'b0, 16};
    vecs[3] = '{16'hFFFF,  8'd1,   16'hFFFF,   8'd0,   1'b0, 16};
    vecs[4] = '{16'd5,     8'd9,   16'd0,      8'd5,   1'b0, 16};
    vecs[5] = '{16'h1234,  8'd0,   16'hFFFF,   8'h34,  1'b1, 0};
    vecs[6] = '{16'd100,   8'd10,  16'd10,     8'd0,   1'b0, 16};
    vecs[7] = '{16'd0,     8'd5,   16'd0,      8'd0,   1'b0, 16};
    vecs[8] = '{16'd300,   8'd255, 16'd1,      8'd45,  1'b0, 16};
    vecs[9] = '{16'd65534, 8'd128, 16'd511,    8'd126, 1'b0, 16};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_Q", {16'd0, Q}, 32'd0);
    check("rst_Rem", {24'd0, Rem}, 32'd0);
    check("rst_dbz", {31'd0, dbz}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-pressure: result held, in_ready low, stray operands ignored.
    out_ready = 1'b0;
    start_op(16'd1000, 8'd7);
    wait_done(lat);
    check("bp_latency", lat, 16);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      A        = 16'd7;
      B        = 8'd1;
      @(negedge clk);
      check("bp_hold_Q", {16'd0, Q}, 32'd142);
      check("bp_hold_Rem", {24'd0, Rem}, 32'd6);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    run_vec('{16'd200, 8'd3, 16'd66, 8'd2, 1'b0, 16}, "bp_next");

    // Reset eight cycles into a busy operation.
    start_op(16'd50000, 8'd200);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr_out_valid", {31'd0, out_valid}, 32'd0);
    check("mr_Q", {16'd0, Q}, 32'd0);
    check("mr_Rem", {24'd0, Rem}, 32'd0);
    check("mr_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_no_emit", {31'd0, out_valid}, 32'd0);
    run_vec(vecs[1], "mr_next");

    // Random regression with random issue gaps and out_ready toggling.
    handshakes = 0;
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] ra, eq;
      logic [7:0]  rb, er;
      logic        ed, got;
      int          n, kind;
      kind = $urandom_range(0, 7);
      ra   = 16'($urandom);
      rb   = 8'($urandom);
      if (kind == 0) rb = 8'd0;
      else if (kind == 1) rb = 8'd1;
      else if (kind == 2) begin
        if (rb == 8'd0) rb = 8'd1;
        ra = 16'($urandom_range(0, int'(rb) - 1));
      end
      if (rb == 8'd0) begin
        eq = 16'hFFFF;
        er = ra[7:0];
        ed = 1'b1;
      end else begin
        eq = ra / {8'd0, rb};
        er = 8'(ra % {8'd0, rb});
        ed = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_op(ra, rb);
      got = 1'b0;
      n   = 0;
      while (!got && n < 200) begin
        logic        ov, od;
        logic [15:0] oq;
        logic [7:0]  orm;
        ov        = out_valid;
        oq        = Q;
        orm       = Rem;
        od        = dbz;
        out_ready = 1'($urandom);
        @(posedge clk);
        if (ov && out_ready) begin
          got = 1'b1;
          handshakes++;
          checks++;
          if (oq !== eq || orm !== er || od !== ed) begin
            errors++;
            $display("FAIL rand%0d A=%0d B=%0d actual Q=%0d Rem=%0d dbz=%0b required Q=%0d Rem=%0d dbz=%0b",
                     i, ra, rb, oq, orm, od, eq, er, ed);
          end
        end
        @(negedge clk);
        n++;
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL rand%0d_timeout actual=no_result required=result", i);
      end
      check("rand_no_dup", {31'd0, out_valid}, 32'd0);
    end
    check("rand_handshakes", handshakes, 1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
